// File: rtl/axi_isolate_gate.sv
// AXI AW/AR isolation gate: counts outstanding writes/reads, closes the
// address channels on request and acknowledges once in-flight traffic drains.
module axi_isolate_gate #(
   parameter int unsigned COUNTER_SIZE = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic isolate_i,
   output logic isolated_o,
   output logic busy_o,
   input  logic slv_aw_valid_i,
   output logic slv_aw_ready_o,
   output logic mst_aw_valid_o,
   input  logic mst_aw_ready_i,
   input  logic slv_ar_valid_i,
   output logic slv_ar_ready_o,
   output logic mst_ar_valid_o,
   input  logic mst_ar_ready_i,
   input  logic b_valid_i,
   input  logic b_ready_i,
   input  logic r_valid_i,
   input  logic r_ready_i,
   input  logic r_last_i
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      ISOLATED = 2'd2
   } state_e;

   localparam logic [COUNTER_SIZE-1:0] CNT_MAX = '1;

   state_e                  state_q, state_d;
   logic [COUNTER_SIZE-1:0] aw_cnt_q, aw_cnt_d;
   logic [COUNTER_SIZE-1:0] ar_cnt_q, ar_cnt_d;
   logic                    aw_lock_q, aw_lock_d;
   logic                    ar_lock_q, ar_lock_d;

   logic aw_open, ar_open;
   logic aw_acc, ar_acc, b_done, r_done;
   logic drained;

   // A forwarded-but-unaccepted valid keeps its gate open so it never retracts.
   assign aw_open = aw_lock_q | ((state_q == RUN) & (aw_cnt_q != CNT_MAX));
   assign ar_open = ar_lock_q | ((state_q == RUN) & (ar_cnt_q != CNT_MAX));

   assign mst_aw_valid_o = slv_aw_valid_i & aw_open;
   assign slv_aw_ready_o = mst_aw_ready_i & aw_open;
   assign mst_ar_valid_o = slv_ar_valid_i & ar_open;
   assign slv_ar_ready_o = mst_ar_ready_i & ar_open;

   assign aw_acc = mst_aw_valid_o & mst_aw_ready_i;
   assign ar_acc = mst_ar_valid_o & mst_ar_ready_i;
   assign b_done = b_valid_i & b_ready_i;
   assign r_done = r_valid_i & r_ready_i & r_last_i;

   assign drained = (aw_cnt_q == '0) & (ar_cnt_q == '0) & ~aw_lock_q & ~ar_lock_q;

   assign busy_o     = (aw_cnt_q != '0) | (ar_cnt_q != '0);
   assign isolated_o = (state_q == ISOLATED);

   always_comb begin
      aw_cnt_d = aw_cnt_q;
      if (aw_acc && !b_done && aw_cnt_q != CNT_MAX) begin
         aw_cnt_d = aw_cnt_q + 1'b1;
      end else if (b_done && !aw_acc && aw_cnt_q != '0) begin
         aw_cnt_d = aw_cnt_q - 1'b1;
      end
   end

   always_comb begin
      ar_cnt_d = ar_cnt_q;
      if (ar_acc && !r_done && ar_cnt_q != CNT_MAX) begin
         ar_cnt_d = ar_cnt_q + 1'b1;
      end else if (r_done && !ar_acc && ar_cnt_q != '0) begin
         ar_cnt_d = ar_cnt_q - 1'b1;
      end
   end

   always_comb begin
      aw_lock_d = aw_lock_q;
      ar_lock_d = ar_lock_q;
      if (aw_acc) begin
         aw_lock_d = 1'b0;
      end else if (mst_aw_valid_o) begin
         aw_lock_d = 1'b1;
      end
      if (ar_acc) begin
         ar_lock_d = 1'b0;
      end else if (mst_ar_valid_o) begin
         ar_lock_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (isolate_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (!isolate_i) begin
               state_d = RUN;
            end else if (drained) begin
               state_d = ISOLATED;
            end
         end
         ISOLATED: begin
            if (!isolate_i) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= RUN;
         aw_cnt_q  <= '0;
         ar_cnt_q  <= '0;
         aw_lock_q <= 1'b0;
         ar_lock_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_cnt_q  <= aw_cnt_d;
         ar_cnt_q  <= ar_cnt_d;
         aw_lock_q <= aw_lock_d;
         ar_lock_q <= ar_lock_d;
      end
   end

   // A completion with nothing outstanding is an upstream protocol error.
   a_no_b_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(b_done && !aw_acc && aw_cnt_q == '0));
   a_no_r_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(r_done && !ar_acc && ar_cnt_q == '0));

endmodule

// File: tb/tb_axi_isolate_gate.sv
// Self-checking bench for axi_isolate_gate: constant vector table, directed
// isolation sequences and randomized traffic against a transaction-count model.
module tb_axi_isolate_gate;

   localparam int CS  = 2;
   localparam int MAX = (1 << CS) - 1;

   logic clk = 1'b0;
   logic rst_n;
   logic iso, iso_o, busy;
   logic awv, awr, m_awv, s_awr;
   logic arv, arr, m_arv, s_arr;
   logic bv, br, rv, rr, rl;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   typedef enum int {M_RUN, M_DRAIN, M_ISO} mode_t;
   mode_t mode;
   int    aw_n, ar_n;
   bit    aw_pend, ar_pend;

   typedef struct {
      logic [9:0] in;
      logic [5:0] exp;
   } vec_t;
   vec_t tbl[$];

   axi_isolate_gate #(.COUNTER_SIZE(CS)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .isolate_i      (iso),
      .isolated_o     (iso_o),
      .busy_o         (busy),
      .slv_aw_valid_i (awv),
      .slv_aw_ready_o (s_awr),
      .mst_aw_valid_o (m_awv),
      .mst_aw_ready_i (awr),
      .slv_ar_valid_i (arv),
      .slv_ar_ready_o (s_arr),
      .mst_ar_valid_o (m_arv),
      .mst_ar_ready_i (arr),
      .b_valid_i      (bv),
      .b_ready_i      (br),
      .r_valid_i      (rv),
      .r_ready_i      (rr),
      .r_last_i       (rl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   function automatic logic [5:0] dut_out();
      return {m_awv, s_awr, m_arv, s_arr, busy, iso_o};
   endfunction

   function automatic logic [5:0] model_out();
      bit aw_open, ar_open;
      aw_open = aw_pend || (mode == M_RUN && aw_n < MAX);
      ar_open = ar_pend || (mode == M_RUN && ar_n < MAX);
      return {awv & aw_open, awr & aw_open, arv & ar_open, arr & ar_open,
              logic'(aw_n > 0 || ar_n > 0), logic'(mode == M_ISO)};
   endfunction

   task automatic model_clear();
      mode = M_RUN; aw_n = 0; ar_n = 0; aw_pend = 0; ar_pend = 0;
   endtask

   task automatic model_update(input logic [5:0] e);
      bit aw_acc, ar_acc, b_done, r_done, drained;
      aw_acc  = e[5] & awr;
      ar_acc  = e[3] & arr;
      b_done  = bv & br;
      r_done  = rv & rr & rl;
      drained = aw_n == 0 && ar_n == 0 && !aw_pend && !ar_pend;
      if (aw_acc && !b_done) aw_n = (aw_n < MAX) ? aw_n + 1 : MAX;
      if (b_done && !aw_acc) aw_n = (aw_n > 0) ? aw_n - 1 : 0;
      if (ar_acc && !r_done) ar_n = (ar_n < MAX) ? ar_n + 1 : MAX;
      if (r_done && !ar_acc) ar_n = (ar_n > 0) ? ar_n - 1 : 0;
      if (aw_acc) aw_pend = 0; else if (e[5]) aw_pend = 1;
      if (ar_acc) ar_pend = 0; else if (e[3]) ar_pend = 1;
      case (mode)
         M_RUN:   if (iso) mode = M_DRAIN;
         M_DRAIN: if (!iso) mode = M_RUN; else if (drained) mode = M_ISO;
         default: if (!iso) mode = M_RUN;
      endcase
   endtask

   task automatic drive(input logic [9:0] in);
      @(negedge clk);
      {iso, awv, awr, arv, arr, bv, br, rv, rr, rl} = in;
      #1;
   endtask

   // One cycle: compare outputs against the model, optionally pin isolated_o.
   task automatic step(input string name, input logic [9:0] in, input int exp_iso = -1);
      logic [5:0] e;
      drive(in);
      e = model_out();
      chk(name, dut_out(), e);
      if (exp_iso >= 0) chk({name, "_iso"}, {5'b0, iso_o}, {5'b0, logic'(exp_iso)});
      @(posedge clk);
      model_update(e);
   endtask

   task automatic async_reset(input string name);
      @(negedge clk);
      #2 rst_n = 1'b0;
      {iso, awv, awr, arv, arr, bv, br, rv, rr, rl} = '0;
      #1;
      chk(name, dut_out(), 6'b000000);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      {iso, awv, awr, arv, arr, bv, br, rv, rr, rl} = '0;
      model_clear();
      //        iso aw  ar  b  r        out: maw saw mar sar busy iso
      tbl.push_back('{10'b0_00_00_00_000, 6'b000000});
      tbl.push_back('{10'b0_11_00_00_000, 6'b110000});
      tbl.push_back('{10'b0_11_00_00_000, 6'b110010});
      tbl.push_back('{10'b0_11_00_00_000, 6'b110010});
      tbl.push_back('{10'b0_11_00_00_000, 6'b000010});
      tbl.push_back('{10'b0_11_00_11_000, 6'b000010});
      tbl.push_back('{10'b0_00_00_11_000, 6'b000010});
      tbl.push_back('{10'b0_00_00_11_000, 6'b000010});
      tbl.push_back('{10'b0_00_00_00_000, 6'b000000});
      tbl.push_back('{10'b0_00_11_00_000, 6'b001100});
      tbl.push_back('{10'b0_00_10_00_000, 6'b001010});
      tbl.push_back('{10'b1_00_10_00_000, 6'b001010});
      tbl.push_back('{10'b1_00_11_00_000, 6'b001110});
      tbl.push_back('{10'b1_00_11_00_000, 6'b000010});
      tbl.push_back('{10'b1_00_00_00_111, 6'b000010});
      tbl.push_back('{10'b1_00_00_00_111, 6'b000010});
      tbl.push_back('{10'b1_00_00_00_000, 6'b000000});
      tbl.push_back('{10'b1_11_00_00_000, 6'b000001});
      tbl.push_back('{10'b0_11_00_00_000, 6'b000001});
      tbl.push_back('{10'b0_11_00_00_000, 6'b110000});
      tbl.push_back('{10'b0_11_00_11_000, 6'b110010});
      tbl.push_back('{10'b0_00_00_11_000, 6'b000010});
      tbl.push_back('{10'b0_00_00_00_000, 6'b000000});

      #1;
      chk("reset_state", dut_out(), 6'b000000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         logic [5:0] e;
         drive(tbl[i].in);
         e = model_out();
         chk($sformatf("tbl[%0d]", i), dut_out(), tbl[i].exp);
         @(posedge clk);
         model_update(e);
      end

      // Idle isolate: isolated_o rises after the second edge, then release.
      step("idle_n",   10'b1_00_00_00_000, 0);
      step("idle_n1",  10'b1_00_00_00_000, 0);
      step("idle_iso", 10'b1_10_00_00_000, 1);
      step("idle_rel", 10'b0_10_00_00_000, 1);
      step("idle_run", 10'b0_00_00_00_000, 0);

      // Two writes outstanding: isolation waits for the second B.
      step("w2_a0", 10'b0_11_00_00_000);
      step("w2_a1", 10'b0_11_00_00_000);
      step("w2_d0", 10'b1_00_00_00_000, 0);
      step("w2_d1", 10'b1_00_00_00_000, 0);
      step("w2_b0", 10'b1_00_00_11_000, 0);
      step("w2_b1", 10'b1_00_00_11_000, 0);
      step("w2_e1", 10'b1_00_00_00_000, 0);
      step("w2_iso", 10'b1_00_00_00_000, 1);
      step("w2_rel", 10'b0_00_00_00_000, 1);

      // Stalled AW forwarded through DRAIN, counted, then drained.
      step("pd_lock", 10'b0_10_00_00_000, 0);
      step("pd_dr",   10'b1_10_00_00_000, 0);
      step("pd_hold", 10'b1_10_00_00_000, 0);
      step("pd_acc",  10'b1_11_00_00_000, 0);
      step("pd_wait", 10'b1_00_00_00_000, 0);
      step("pd_b",    10'b1_00_00_11_000, 0);
      step("pd_e1",   10'b1_00_00_00_000, 0);
      step("pd_iso",  10'b1_00_00_00_000, 1);
      step("pd_rel",  10'b0_00_00_00_000, 1);

      // Abort DRAIN: gate reopens, isolated_o never rises.
      step("ab_a",   10'b0_11_00_00_000, 0);
      step("ab_d0",  10'b1_00_00_00_000, 0);
      step("ab_d1",  10'b1_00_00_00_000, 0);
      step("ab_off", 10'b0_00_00_00_000, 0);
      step("ab_run", 10'b0_11_00_00_000, 0);
      async_reset("rst_busy");

      // Reset while isolated clears isolated_o immediately.
      step("ri_0", 10'b1_00_00_00_000, 0);
      step("ri_1", 10'b1_00_00_00_000, 0);
      step("ri_2", 10'b1_00_00_00_000, 1);
      async_reset("rst_iso");

      for (int k = 0; k < 600; k++) begin
         logic [9:0] in;
         logic ib;
         ib = iso;
         if ($urandom_range(0, 19) == 0) ib = ~ib;
         in = {ib, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)};
         if (aw_n == 0) in[4] = 1'b0;
         if (ar_n == 0) in[2] = 1'b0;
         step($sformatf("rnd[%0d]", k), in);
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
